// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin arbiter and sequencer sharing one ULA between two
// requesters. Accepts one operation at a time, drives the ULA from registers,
// captures its result/overflow and hands them back to the requester that owns
// the operation.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_a/_b/_op          operands and opcode (00 SUB, 01 ADD, 10 EQU, 11 SLT)
//   rsp{0,1}_valid/_ready      response handshake per requester
//   rsp_result, rsp_v          registered result and overflow, shared
//   ula_a, ula_b, ula_op       registered operands/opcode to the ULA
//   ula_result, ula_v          combinational result/overflow from the ULA
//   busy                       high in any state other than IDLE
//
// state | meaning
// IDLE  | waiting for a request; ready is granted combinationally
// EXEC  | ULA evaluating the latched operands; result captured at the edge
// RESP  | result presented to the owner until its rsp_ready
module ula_arbiter #(
  parameter int BITS = 63
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [BITS:0] req0_a,
  input  logic [BITS:0] req0_b,
  input  logic [1:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [BITS:0] req1_a,
  input  logic [BITS:0] req1_b,
  input  logic [1:0]    req1_op,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [BITS:0] rsp_result,
  output logic          rsp_v,
  output logic [BITS:0] ula_a,
  output logic [BITS:0] ula_b,
  output logic [1:0]    ula_op,
  input  logic [BITS:0] ula_result,
  input  logic          ula_v,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;   // requester preferred when both are valid
  logic   owner;  // requester that owns the in-flight operation
  logic   grant0;
  logic   grant1;
  logic   rsp_done;

  // Grants exist only in IDLE, so at most one ready can be high per cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !prio))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  // Only the owner's rsp_ready can close the response.
  assign rsp_done = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_op     <= 2'b01;
      rsp_result <= '0;
      rsp_v      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            ula_a  <= req0_a;
            ula_b  <= req0_b;
            ula_op <= req0_op;
            owner  <= 1'b0;
            state  <= EXEC;
          end else if (grant1) begin
            ula_a  <= req1_a;
            ula_b  <= req1_b;
            ula_op <= req1_op;
            owner  <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= ula_result;
          // Overflow is meaningful only for arithmetic opcodes (SUB/ADD).
          rsp_v      <= ula_v & ~ula_op[1];
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            prio       <= ~owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a behavioural ULA model attached.
module tb_ula_arbiter;

  localparam int BITS = 63;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [BITS:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [BITS:0] rsp_result;
  logic          rsp_v;
  logic [BITS:0] ula_a, ula_b, ula_result;
  logic [1:0]    ula_op;
  logic          ula_v;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  ula_arbiter #(.BITS(BITS)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_v(rsp_v),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_result(ula_result), .ula_v(ula_v),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ULA model. Its overflow output is deliberately 1 for EQU/SLT so the
  // arbiter's masking of rsp_v is observable.
  always_comb begin
    ula_result = '0;
    ula_v      = 1'b0;
    case (ula_op)
      2'b00: begin
        ula_result = ula_a - ula_b;
        ula_v = (ula_a[BITS] != ula_b[BITS]) && (ula_result[BITS] != ula_a[BITS]);
      end
      2'b01: begin
        ula_result = ula_a + ula_b;
        ula_v = (ula_a[BITS] == ula_b[BITS]) && (ula_result[BITS] != ula_a[BITS]);
      end
      2'b10: begin
        ula_result = {{BITS{1'b0}}, (ula_a == ula_b)};
        ula_v = 1'b1;
      end
      default: begin
        ula_result = {{BITS{1'b0}}, ($signed(ula_a) < $signed(ula_b))};
        ula_v = 1'b1;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation from requester id with the owner responding at once.
  task automatic run_op(input bit id, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic [63:0] er, input logic ev);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    #1;
    chk("ready_own", id ? req1_ready : req0_ready, 1);
    chk("ready_other", id ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_busy", busy, 1);
    chk("exec_ula_a", ula_a, a);
    chk("exec_ula_b", ula_b, b);
    chk("exec_ula_op", ula_op, op);
    chk("exec_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    tick();
    chk("rsp_valid_pair", {rsp1_valid, rsp0_valid}, id ? 2'b10 : 2'b01);
    chk("rsp_result", rsp_result, er);
    chk("rsp_v", rsp_v, ev);
    if (id == 1'b0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("done_busy", busy, 0);
    chk("done_no_rsp", {rsp0_valid, rsp1_valid}, 0);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Reset values
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_v", rsp_v, 0);
    chk("rst_ula_a", ula_a, 0);
    chk("rst_ula_b", ula_b, 0);
    chk("rst_ula_op", ula_op, 2'b01);
    chk("rst_busy", busy, 0);

    // Basic ADD and overflow cases
    run_op(1'b0, 64'd5, 64'd7, 2'b01, 64'd12, 1'b0);
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'd1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    run_op(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b01, 64'h8000_0000_0000_0000, 1'b1);

    // Both requesters continuously valid: grants 0,1,0,1
    req0_valid = 1'b1; req0_a = 64'd10; req0_b = 64'd3; req0_op = 2'b01;
    req1_valid = 1'b1; req1_a = 64'd10; req1_b = 64'd3; req1_op = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", {req1_ready, req0_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      chk("rr_exec_ready", {req1_ready, req0_ready}, 0);
      tick();
      chk("rr_resp_ready", {req1_ready, req0_ready}, 0);
      chk("rr_rsp_valid", {rsp1_valid, rsp0_valid}, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("rr_result", rsp_result, (i % 2 == 1) ? 64'd7 : 64'd13);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Compare ops
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b11, 64'd1, 1'b0);
    run_op(1'b0, 64'h1234, 64'h1234, 2'b10, 64'd1, 1'b0);
    run_op(1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 64'd0, 1'b0);

    // Owner stalls in RESP; req1 and rsp1_ready must have no effect
    req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2; req0_op = 2'b01;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 64'd4; req1_b = 64'd4; req1_op = 2'b01;
    rsp1_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp0_valid", rsp0_valid, 1);
      chk("stall_rsp1_valid", rsp1_valid, 0);
      chk("stall_result", rsp_result, 64'd3);
      chk("stall_busy", busy, 1);
      chk("stall_req1_ready", req1_ready, 0);
      tick();
    end
    req1_valid = 1'b0;
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk("stall_release_busy", busy, 0);
    chk("stall_release_rsp", {rsp0_valid, rsp1_valid}, 0);

    // Reset during EXEC aborts the operation
    req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_op = 2'b00;
    tick();
    req0_valid = 1'b0;
    chk("abort_in_exec", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ula_op", ula_op, 2'b01);
    chk("abort_result", rsp_result, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_rsp", {rsp0_valid, rsp1_valid}, 0);
      tick();
    end
    run_op(1'b1, 64'd100, 64'd23, 2'b01, 64'd123, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
